// File: rtl/op_dispatch_sequencer.sv
// Command FIFO plus issue FSM feeding the ALU stage: each queued {op, count}
// is driven on op_code for count consecutive cycles, back-to-back without bubbles.
module op_dispatch_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [CNT_W-1:0]         cmd_count,
  input  logic                     flush,
  output logic [2:0]               op_code,
  output logic                     op_valid,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     err_drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE, ISSUE} state_t;
  typedef struct packed {
    logic [2:0]       op;
    logic [CNT_W-1:0] cnt;
  } cmd_t;

  cmd_t             mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  state_t           state_q;
  logic [2:0]       op_reg_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       op_code_q;
  logic             op_valid_q, err_drop_q;

  logic accept, legal, push, drop, pop, last_beat;
  cmd_t head;

  assign cmd_ready = (level_q < LW'(DEPTH));
  assign legal     = (cmd_op != 3'b111) && (cmd_count != '0);
  assign accept    = cmd_valid && cmd_ready && !flush;
  assign push      = accept && legal;
  assign drop      = accept && !legal;
  assign last_beat = (state_q == ISSUE) && (cnt_q == CNT_W'(1));
  // Pop on the last beat too, so the next op follows with no idle cycle.
  assign pop       = !flush && (level_q != '0) && ((state_q == IDLE) || last_beat);
  assign head      = mem_q[rd_ptr_q];
  assign level_d   = level_q + LW'(push) - LW'(pop);

  assign op_code    = op_code_q;
  assign op_valid   = op_valid_q;
  assign err_drop   = err_drop_q;
  assign fifo_level = level_q;
  assign busy       = (state_q == ISSUE) || (level_q != '0);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{op: cmd_op, cnt: cmd_count};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      op_reg_q   <= 3'b000;
      cnt_q      <= '0;
      op_code_q  <= 3'b000;
      op_valid_q <= 1'b0;
      err_drop_q <= 1'b0;
    end else begin
      err_drop_q <= drop;
      if (flush) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        op_code_q  <= 3'b000;
        op_valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            op_valid_q <= 1'b0;
            op_code_q  <= 3'b000;
            if (pop) begin
              op_reg_q <= head.op;
              cnt_q    <= head.cnt;
              state_q  <= ISSUE;
            end
          end
          ISSUE: begin
            op_valid_q <= 1'b1;
            op_code_q  <= op_reg_q;
            if (last_beat) begin
              if (pop) begin
                op_reg_q <= head.op;
                cnt_q    <= head.cnt;
              end else begin
                cnt_q   <= '0;
                state_q <= IDLE;
              end
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/op_dispatch_sequencer.md
Name: op_dispatch_sequencer

Overview:
- Upstream feeder for the enum-decoded ALU stage. That stage registers a 3-bit op_code every clk and computes from it.
- Buffers incoming operation commands (op plus repeat count) in a small FIFO.
- Drives op_code one op per cycle, repeating each op for its count, with no bubbles between back-to-back commands.
- Drops illegal commands (INVALID op or zero count) at the input and flags them.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 4, width of the repeat-count field.

Ports:
- clk  input  1  clock.
- reset_n  input  1  reset, asynchronous, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept a command.
- cmd_op  input  3  operation code: ADD=0, SUB=1, MUL=2, DIV=3, AND=4, OR=5, XOR=6, INVALID=7.
- cmd_count  input  CNT_W  number of consecutive cycles to issue cmd_op.
- flush  input  1  synchronous abort of all queued and in-flight work.
- op_code  output  3  op driven to the ALU stage.
- op_valid  output  1  op_code is a dispatched op this cycle.
- busy  output  1  work queued or issuing.
- fifo_level  output  $clog2(DEPTH)+1  entries currently stored.
- err_drop  output  1  one-cycle pulse, illegal command accepted and discarded.

Behaviour:
- Reset, asynchronous:
  - FIFO empty, fifo_level=0.
  - FSM in IDLE.
  - op_code=3'b000 (ADD), op_valid=0, err_drop=0, busy=0.
  - cmd_ready=1 once reset deasserts.
- Registered outputs: op_code, op_valid, err_drop.
- Combinational outputs:
  - cmd_ready = (fifo_level < DEPTH); no full-bypass, so a full FIFO gives ready=0 even if a pop happens this cycle.
  - busy = (state==ISSUE) || (fifo_level != 0).
- Accept: cmd_valid && cmd_ready at a rising edge.
  - If cmd_op==3'b111 or cmd_count==0: the command is not written, and err_drop=1 for the next cycle.
  - Otherwise {cmd_op, cmd_count} is written at the tail.
- FSM states are IDLE and ISSUE.
  - IDLE: op_valid=0 and op_code=3'b000. If the FIFO is non-empty, pop the head, load op_reg and cnt=count, go to ISSUE.
  - ISSUE: each cycle op_valid=1 and op_code=op_reg, and cnt decrements.
  - When cnt==1 (last beat) and the FIFO is non-empty: pop the next head in the same cycle; the following cycle issues the new op with no gap.
  - When cnt==1 and the FIFO is empty: return to IDLE, and op_valid=0 next cycle.
- Latency: a command accepted at edge N into an empty, idle block gives its first op_valid=1 in the cycle after edge N+2 (write, then pop/load, then drive).
- An op with count K produces exactly K consecutive op_valid cycles.
- Simultaneous push and pop: allowed when not full; fifo_level is unchanged.
- FIFO pointers wrap modulo DEPTH. fifo_level never exceeds DEPTH and never underflows.
- Flush, on a rising edge:
  - FIFO cleared, FSM to IDLE, cnt=0.
  - op_valid=0 and op_code=3'b000 from the next cycle.
  - A push in the same cycle is discarded, with no err_drop.
  - Flush takes priority over push, pop and drop.
- Reset mid-issue: immediate return to reset values; no partial op is replayed.
- Count arithmetic is unsigned CNT_W bits; max repeat is 2^CNT_W-1 (15 by default).

Test Plan:
- Reset, then push {SUB, 3} -> op_valid high exactly 3 cycles starting 2 cycles after accept, op_code=3'b001, then op_valid=0 and op_code=3'b000.
- Back-to-back: push {MUL, 2}, {XOR, 1}, {OR, 2} on consecutive cycles -> op_code sequence 2,2,6,5,5 with op_valid continuously high, no bubble.
- Illegal: push {INVALID, 4}, then {ADD, 0} -> two err_drop pulses, fifo_level stays 0, op_valid never asserts.
- Full: hold the ALU busy on {AND, 15}, then push 5 commands -> cmd_ready=0 after the 4th, fifo_level=4, 5th held until a pop frees a slot.
- Flush: during the issue of {DIV, 10} with 2 queued, assert flush for 1 cycle alongside a push -> next cycle op_valid=0, fifo_level=0, busy=0, pushed command lost.
- Async reset asserted mid-ISSUE (between clock edges) -> outputs go to reset values immediately; after release, a push of {ADD, 1} issues normally.
